// File: rtl/mips_prog_loader_if.sv
// Bundle between an instruction-word source and the mips_32 program loader:
// word stream in, instruction-memory writes and core boot controls out.
interface mips_prog_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              start;
  logic [31:0]       load_pc;
  logic              word_valid;
  logic [31:0]       word_data;
  logic              word_last;
  logic              word_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_reset;
  logic [31:0]       start_pc;
  logic [ADDR_W:0]   word_count;
  logic              busy;
  logic              done;
  logic              error;

  // Upstream source / boot controller side
  modport master (
    output start, load_pc, word_valid, word_data, word_last,
    input  word_ready, imem_we, imem_addr, imem_wdata, core_reset,
           start_pc, word_count, busy, done, error
  );

  // Loader side
  modport slave (
    input  start, load_pc, word_valid, word_data, word_last,
    output word_ready, imem_we, imem_addr, imem_wdata, core_reset,
           start_pc, word_count, busy, done, error
  );
endinterface

// File: rtl/mips_prog_loader.sv
// Boot-time loader: streams instruction words into imem, holds mips_32 in reset
// while loading, then releases it with the latched start PC.
module mips_prog_loader #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned RESET_HOLD = 4
) (
  input  logic             clk,
  input  logic             reset,
  mips_prog_loader_if.slave bus
);

  localparam int unsigned HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam int unsigned CNT_W  = ADDR_W + 1;

  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
  localparam logic [CNT_W-1:0]  COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_RUN,
    S_ERR
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [HOLD_W-1:0] hold_q;
  logic              word_ready_q;
  logic              imem_we_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [31:0]       imem_wdata_q;
  logic              core_reset_q;
  logic [31:0]       start_pc_q;
  logic [CNT_W-1:0]  word_count_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;

  logic              accept_c;
  logic [ADDR_W-1:0] addr_d;
  logic [CNT_W-1:0]  word_count_d;

  assign accept_c = bus.word_valid & word_ready_q;

  // Address stops at the top of memory instead of wrapping; count saturates.
  assign addr_d       = (addr_q == ADDR_MAX) ? addr_q : addr_q + ADDR_W'(1);
  assign word_count_d = (word_count_q == COUNT_MAX) ? word_count_q
                                                    : word_count_q + CNT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      hold_q       <= '0;
      word_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_reset_q <= 1'b1;
      start_pc_q   <= '0;
      word_count_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      case (state_q)
        // A start from any resting state opens a fresh session.
        S_IDLE, S_RUN, S_ERR: begin
          if (bus.start) begin
            state_q      <= S_LOAD;
            start_pc_q   <= bus.load_pc;
            addr_q       <= '0;
            hold_q       <= '0;
            word_count_q <= '0;
            word_ready_q <= 1'b1;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
          end
        end

        S_LOAD: begin
          if (accept_c) begin
            imem_we_q    <= 1'b1;
            imem_addr_q  <= addr_q;
            imem_wdata_q <= bus.word_data;
            word_count_q <= word_count_d;
            addr_q       <= addr_d;
            if (bus.word_last) begin
              state_q      <= S_HOLD;
              word_ready_q <= 1'b0;
              hold_q       <= '0;
            end else if (addr_q == ADDR_MAX) begin
              state_q      <= S_ERR;
              word_ready_q <= 1'b0;
              busy_q       <= 1'b0;
              error_q      <= 1'b1;
            end
          end
        end

        // Last write lands on the first HOLD cycle, well before release.
        S_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            state_q      <= S_RUN;
            core_reset_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
          end else begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end

        default: begin
          state_q      <= S_IDLE;
          word_ready_q <= 1'b0;
          core_reset_q <= 1'b1;
          busy_q       <= 1'b0;
          done_q       <= 1'b0;
          error_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.word_ready = word_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign bus.core_reset = core_reset_q;
  assign bus.start_pc   = start_pc_q;
  assign bus.word_count = word_count_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;

endmodule
